// File: rtl/ins_cache_dm.sv
// Direct-mapped read-only instruction cache with a line-refill FSM on a req/ack memory port.
// Define ICACHE_STATS_EN to add saturating hit/miss counters (hit_count_out, miss_count_out).
module ins_cache_dm #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned LINES          = 16,
    parameter int unsigned WORDS_PER_LINE = 4
) (
    input  logic                  clock_in,
    input  logic                  reset_in,
    input  logic [31:0]           pc_addr_in,
    input  logic                  fetch_valid_in,
    output logic                  fetch_ready_out,
    input  logic                  flush_in,
    output logic [DATA_WIDTH-1:0] ins_out,
    output logic                  ins_valid_out,
    output logic                  hit_out,
    output logic [31:0]           mem_addr_out,
    output logic                  mem_req_out,
    input  logic                  mem_ack_in,
    input  logic [DATA_WIDTH-1:0] mem_data_in
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]           hit_count_out,
    output logic [31:0]           miss_count_out
`endif
);

    localparam int unsigned WORD_BITS   = $clog2(WORDS_PER_LINE);
    localparam int unsigned INDEX_BITS  = $clog2(LINES);
    localparam int unsigned OFFSET_BITS = 2 + WORD_BITS;
    localparam int unsigned TAG_BITS    = 32 - OFFSET_BITS - INDEX_BITS;
    localparam int unsigned ENTRIES     = LINES * WORDS_PER_LINE;

    localparam logic [WORD_BITS-1:0] LastWord = WORD_BITS'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {
        StIdle,
        StLookup,
        StRefill,
        StRespond
    } state_e;

    state_e state_q, state_d;

    logic [31:2]           addr_q, addr_d;
    logic [WORD_BITS-1:0]  cnt_q, cnt_d;
    logic [LINES-1:0]      valid_q, valid_d;
    logic [DATA_WIDTH-1:0] ins_q, ins_d;
    logic                  flushed_q, flushed_d;

    logic [TAG_BITS-1:0]   tag_mem  [LINES];
    logic [DATA_WIDTH-1:0] data_mem [ENTRIES];

    logic [WORD_BITS-1:0]  req_word;
    logic [INDEX_BITS-1:0] req_index;
    logic [TAG_BITS-1:0]   req_tag;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  tag_match;

    logic data_we;
    logic tag_we;
    logic lookup_hit;
    logic lookup_miss;

    // Byte-offset bits of the PC never select anything.
    logic unused_pc_bits;
    assign unused_pc_bits = ^pc_addr_in[1:0];

    assign req_word  = addr_q[OFFSET_BITS-1:2];
    assign req_index = addr_q[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS];
    assign req_tag   = addr_q[31:OFFSET_BITS+INDEX_BITS];
    assign rd_word   = data_mem[{req_index, req_word}];
    assign tag_match = valid_q[req_index] && (tag_mem[req_index] == req_tag);

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        cnt_d           = cnt_q;
        valid_d         = valid_q;
        ins_d           = ins_q;
        flushed_d       = flushed_q;
        fetch_ready_out = 1'b0;
        ins_valid_out   = 1'b0;
        hit_out         = 1'b0;
        mem_req_out     = 1'b0;
        mem_addr_out    = '0;
        data_we         = 1'b0;
        tag_we          = 1'b0;
        lookup_hit      = 1'b0;
        lookup_miss     = 1'b0;

        unique case (state_q)
            StIdle: begin
                fetch_ready_out = 1'b1;
                if (fetch_valid_in) begin
                    addr_d  = pc_addr_in[31:2];
                    state_d = StLookup;
                end
            end
            StLookup: begin
                if (tag_match) begin
                    ins_valid_out = 1'b1;
                    hit_out       = 1'b1;
                    ins_d         = rd_word;
                    lookup_hit    = 1'b1;
                    state_d       = StIdle;
                end else begin
                    lookup_miss = 1'b1;
                    cnt_d       = '0;
                    flushed_d   = 1'b0;
                    state_d     = StRefill;
                end
            end
            StRefill: begin
                mem_req_out  = 1'b1;
                mem_addr_out = {req_tag, req_index, cnt_q, 2'b00};
                // A flush anywhere in the refill must leave the new line invalid.
                if (flush_in) begin
                    flushed_d = 1'b1;
                end
                if (mem_ack_in) begin
                    data_we = 1'b1;
                    cnt_d   = cnt_q + WORD_BITS'(1);
                    if (cnt_q == LastWord) begin
                        tag_we  = 1'b1;
                        state_d = StRespond;
                        if (!flush_in && !flushed_q) begin
                            valid_d[req_index] = 1'b1;
                        end
                    end
                end
            end
            StRespond: begin
                ins_valid_out = 1'b1;
                ins_d         = rd_word;
                state_d       = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (flush_in) begin
            valid_d = '0;
        end

        ins_out = ins_d;
    end

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            cnt_q     <= '0;
            valid_q   <= '0;
            ins_q     <= '0;
            flushed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            ins_q     <= ins_d;
            flushed_q <= flushed_d;
        end
    end

    // Storage arrays need no reset; the valid bits gate every use.
    always_ff @(posedge clock_in) begin
        if (data_we && !reset_in) begin
            data_mem[{req_index, cnt_q}] <= mem_data_in;
        end
        if (tag_we && !reset_in) begin
            tag_mem[req_index] <= req_tag;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (lookup_hit && (hit_cnt_q != 32'hFFFF_FFFF)) begin
            hit_cnt_d = hit_cnt_q + 32'd1;
        end
        if (lookup_miss && (miss_cnt_q != 32'hFFFF_FFFF)) begin
            miss_cnt_d = miss_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_count_out  = hit_cnt_q;
    assign miss_count_out = miss_cnt_q;
`else
    logic unused_stats;
    assign unused_stats = lookup_hit ^ lookup_miss;
`endif

endmodule

// File: tb/tb_ins_cache_dm.sv
// Randomised self-checking bench for ins_cache_dm against a line-level cache model.
module tb_ins_cache_dm;

    localparam int unsigned LINES      = 16;
    localparam int unsigned WPL        = 4;
    localparam int unsigned LINE_BYTES = 4 * WPL;

    logic        clk = 1'b0;
    logic        reset_in = 1'b1;
    logic [31:0] pc_addr_in = '0;
    logic        fetch_valid_in = 1'b0;
    logic        fetch_ready_out;
    logic        flush_in = 1'b0;
    logic [31:0] ins_out;
    logic        ins_valid_out;
    logic        hit_out;
    logic [31:0] mem_addr_out;
    logic        mem_req_out;
    logic        mem_ack_in = 1'b0;
    logic [31:0] mem_data_in = '0;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count_out;
    logic [31:0] miss_count_out;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Model: which memory block (byte address / LINE_BYTES) each line holds.
    bit          model_valid [LINES];
    int unsigned model_blk   [LINES];
    int unsigned model_hits;
    int unsigned model_misses;

    always #5 clk = ~clk;

    ins_cache_dm #(
        .DATA_WIDTH    (32),
        .LINES         (LINES),
        .WORDS_PER_LINE(WPL)
    ) dut (
        .clock_in       (clk),
        .reset_in       (reset_in),
        .pc_addr_in     (pc_addr_in),
        .fetch_valid_in (fetch_valid_in),
        .fetch_ready_out(fetch_ready_out),
        .flush_in       (flush_in),
        .ins_out        (ins_out),
        .ins_valid_out  (ins_valid_out),
        .hit_out        (hit_out),
        .mem_addr_out   (mem_addr_out),
        .mem_req_out    (mem_req_out),
        .mem_ack_in     (mem_ack_in),
        .mem_data_in    (mem_data_in)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count_out  (hit_count_out),
        .miss_count_out (miss_count_out)
`endif
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    function automatic void model_clear_valid();
        for (int i = 0; i < LINES; i++) model_valid[i] = 1'b0;
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        reset_in = 1'b1;
        repeat (3) @(negedge clk);
        model_clear_valid();
        model_hits   = 0;
        model_misses = 0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++; if (ins_out !== 32'h0) begin n_bad++;
            $display("FAIL reset_ins_out got=%h want=0", ins_out); end
        n_cmp++; if (ins_valid_out !== 1'b0) begin n_bad++;
            $display("FAIL reset_ins_valid got=%b want=0", ins_valid_out); end
        n_cmp++; if (hit_out !== 1'b0) begin n_bad++;
            $display("FAIL reset_hit got=%b want=0", hit_out); end
        n_cmp++; if (mem_req_out !== 1'b0) begin n_bad++;
            $display("FAIL reset_mem_req got=%b want=0", mem_req_out); end
        n_cmp++; if (mem_addr_out !== 32'h0) begin n_bad++;
            $display("FAIL reset_mem_addr got=%h want=0", mem_addr_out); end
        n_cmp++; if (fetch_ready_out !== 1'b1) begin n_bad++;
            $display("FAIL reset_ready got=%b want=1", fetch_ready_out); end
        reset_in = 1'b0;
    endtask

    // One fetch from IDLE to delivery. want_hit<0 lets the model decide.
    // flush_cyc pulses flush_in in that cycle after accept (1 = lookup cycle).
    task automatic do_fetch(input logic [31:0] a, input int want_hit, input int delay,
                            input int flush_cyc, input bit noise, input string name);
        int unsigned blk   = a / LINE_BYTES;
        int unsigned idx   = blk % LINES;
        bit          model_hit = model_valid[idx] && (model_blk[idx] == blk);
        bit          exp_hit = (want_hit >= 0) ? (want_hit != 0) : model_hit;
        int          exp_lat = exp_hit ? 1 : 2 + int'(WPL) * (delay + 1);
        int          cyc = 1;
        int          waitc = 0;
        bit          flushed = 1'b0;
        logic [31:0] hold = '0;
        logic [31:0] want_ins = mem_word(a & 32'hFFFF_FFFC);
        logic [31:0] q[$];

        @(negedge clk);
        n_cmp++; if (fetch_ready_out !== 1'b1) begin n_bad++;
            $display("FAIL %s ready got=%b want=1", name, fetch_ready_out); end
        pc_addr_in     = a;
        fetch_valid_in = 1'b1;
        mem_ack_in     = 1'b0;
        @(negedge clk);
        while (1) begin
            flush_in = (cyc == flush_cyc);
            if (flush_in) begin
                model_clear_valid();
                if (!exp_hit && cyc >= 2) flushed = 1'b1;
            end
            if (ins_valid_out === 1'b1 || cyc >= 200) break;
            fetch_valid_in = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            pc_addr_in     = $urandom;
            if (mem_req_out === 1'b1) begin
                if (waitc > 0) begin
                    n_cmp++; if (mem_addr_out !== hold) begin n_bad++;
                        $display("FAIL %s addr_stable got=%h want=%h", name, mem_addr_out, hold);
                    end
                end
                hold = mem_addr_out;
                if (waitc == delay) begin
                    mem_ack_in  = 1'b1;
                    mem_data_in = mem_word(mem_addr_out);
                    q.push_back(mem_addr_out);
                    waitc = 0;
                end else begin
                    mem_ack_in  = 1'b0;
                    mem_data_in = $urandom;
                    waitc++;
                end
            end else begin
                mem_ack_in  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                mem_data_in = $urandom;
            end
            @(negedge clk);
            cyc++;
        end
        fetch_valid_in = 1'b0;
        mem_ack_in     = 1'b0;

        n_cmp++; if (cyc != exp_lat) begin n_bad++;
            $display("FAIL %s latency got=%0d want=%0d", name, cyc, exp_lat); end
        n_cmp++; if (hit_out !== exp_hit) begin n_bad++;
            $display("FAIL %s hit got=%b want=%b", name, hit_out, exp_hit); end
        n_cmp++; if (ins_out !== want_ins) begin n_bad++;
            $display("FAIL %s ins got=%h want=%h", name, ins_out, want_ins); end
        n_cmp++; if (q.size() != (exp_hit ? 0 : int'(WPL))) begin n_bad++;
            $display("FAIL %s refill_words got=%0d want=%0d", name, q.size(),
                     exp_hit ? 0 : WPL);
        end else begin
            for (int i = 0; i < q.size(); i++) begin
                n_cmp++; if (q[i] !== blk * LINE_BYTES + 4 * i) begin n_bad++;
                    $display("FAIL %s refill_addr%0d got=%h want=%h", name, i, q[i],
                             blk * LINE_BYTES + 4 * i);
                end
            end
        end

        @(negedge clk);
        flush_in = 1'b0;
        n_cmp++; if (ins_valid_out !== 1'b0 || hit_out !== 1'b0) begin n_bad++;
            $display("FAIL %s pulse got=%b/%b want=0/0", name, ins_valid_out, hit_out); end
        n_cmp++; if (ins_out !== want_ins) begin n_bad++;
            $display("FAIL %s ins_hold got=%h want=%h", name, ins_out, want_ins); end

        if (exp_hit) begin
            model_hits++;
        end else begin
            model_misses++;
            model_blk[idx]   = blk;
            model_valid[idx] = !flushed;
        end
    endtask

    task automatic test_hit_miss();
        do_fetch(32'h0000_0000, 0, 0, -1, 1'b0, "cold_0");
        do_fetch(32'h0000_0004, 1, 0, -1, 1'b0, "hit_4");
        do_fetch(32'h0000_0100, 0, 0, -1, 1'b0, "miss_100");
        do_fetch(32'h0000_0000, 0, 0, -1, 1'b0, "conflict_0");
    endtask

    task automatic test_slow_ack();
        do_fetch(32'h0000_0208, 0, 3, -1, 1'b0, "slow_208");
        do_fetch(32'h0000_020C, 1, 3, -1, 1'b0, "slow_hit_20c");
    endtask

    task automatic test_flush();
        @(negedge clk);
        flush_in = 1'b1;
        @(negedge clk);
        flush_in = 1'b0;
        model_clear_valid();
        do_fetch(32'h0000_0008, 0, 0, -1, 1'b0, "flush_idle_8");
        do_fetch(32'h0000_0020, 0, 1, 5, 1'b0, "flush_refill_20");
        do_fetch(32'h0000_0020, 0, 0, -1, 1'b0, "refetch_20");
        do_fetch(32'h0000_0030, 0, 0, -1, 1'b0, "load_30");
        do_fetch(32'h0000_0034, 1, 0, 1, 1'b0, "flush_hit_34");
        do_fetch(32'h0000_0030, 0, 0, -1, 1'b0, "after_flush_30");
    endtask

    task automatic test_reset_mid_refill();
        do_fetch(32'h0000_0000, -1, 0, -1, 1'b0, "preload_0");
        do_fetch(32'h0000_0004, 1, 0, -1, 1'b0, "preload_hit_4");
        @(negedge clk);
        pc_addr_in     = 32'h0000_7F40;
        fetch_valid_in = 1'b1;
        @(negedge clk);
        fetch_valid_in = 1'b0;
        @(negedge clk);
        n_cmp++; if (mem_req_out !== 1'b1 || mem_addr_out !== 32'h0000_7F40) begin n_bad++;
            $display("FAIL rst_refill_req got=%b/%h want=1/00007f40", mem_req_out, mem_addr_out);
        end
        reset_in = 1'b1;
        @(negedge clk);
        reset_in = 1'b0;
        n_cmp++; if (mem_req_out !== 1'b0) begin n_bad++;
            $display("FAIL rst_refill_req_drop got=%b want=0", mem_req_out); end
        n_cmp++; if (fetch_ready_out !== 1'b1) begin n_bad++;
            $display("FAIL rst_refill_ready got=%b want=1", fetch_ready_out); end
        mem_ack_in  = 1'b1;
        mem_data_in = 32'hDEAD_BEEF;
        @(negedge clk);
        mem_ack_in = 1'b0;
        n_cmp++; if (mem_req_out !== 1'b0 || ins_valid_out !== 1'b0) begin n_bad++;
            $display("FAIL rst_late_ack got=%b/%b want=0/0", mem_req_out, ins_valid_out); end
        model_clear_valid();
        model_hits   = 0;
        model_misses = 0;
        do_fetch(32'h0000_0000, 0, 0, -1, 1'b0, "refetch_after_reset");
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            logic [31:0] a;
            int          fc;
            a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 4) |
                (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            fc = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 8)) : -1;
            do_fetch(a, -1, int'($urandom_range(0, 2)), fc, 1'b1, "random");
        end
    endtask

`ifdef ICACHE_STATS_EN
    task automatic test_stats();
        apply_reset();
        reset_in = 1'b0;
        do_fetch(32'h0000_0040, 0, 0, -1, 1'b0, "stats_miss");
        do_fetch(32'h0000_0044, 1, 0, -1, 1'b0, "stats_hit1");
        do_fetch(32'h0000_0048, 1, 0, -1, 1'b0, "stats_hit2");
        do_fetch(32'h0000_0040, 1, 0, -1, 1'b0, "stats_hit3");
        n_cmp++; if (miss_count_out !== 32'd1 || hit_count_out !== 32'd3) begin n_bad++;
            $display("FAIL stats_counts got=%0d/%0d want=1/3", miss_count_out, hit_count_out);
        end
        @(negedge clk);
        flush_in = 1'b1;
        @(negedge clk);
        flush_in = 1'b0;
        model_clear_valid();
        n_cmp++; if (miss_count_out !== 32'd1 || hit_count_out !== 32'd3) begin n_bad++;
            $display("FAIL stats_flush got=%0d/%0d want=1/3", miss_count_out, hit_count_out);
        end
        test_random();
        n_cmp++;
        if (miss_count_out !== model_misses || hit_count_out !== model_hits) begin n_bad++;
            $display("FAIL stats_random got=%0d/%0d want=%0d/%0d", miss_count_out,
                     hit_count_out, model_misses, model_hits);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_hit_miss();
        test_slow_ack();
        test_flush();
        test_reset_mid_refill();
        test_random();
`ifdef ICACHE_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
